// File: rtl/conv_dense_bridge_if.sv
// Stream bundle between the convolution output and the dense-layer input.
// The slave side is the bridge itself; the master side drives the feature stream and consumes the flattened beats.
interface conv_dense_bridge_if #(
  parameter int BitSize  = 32,
  parameter int InLanes  = 2,
  parameter int OutLanes = 2
);
  logic                               in_valid;
  logic [InLanes-1:0][BitSize-1:0]    in_data;
  logic                               in_set_done;
  logic                               in_ready;
  logic                               out_ready;
  logic                               out_valid;
  logic [OutLanes-1:0][BitSize-1:0]   out_data;
  logic                               out_last;
  logic                               out_err;

  modport slave (
    input  in_valid, in_data, in_set_done, out_ready,
    output in_ready, out_valid, out_data, out_last, out_err
  );

  modport master (
    output in_valid, in_data, in_set_done, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_err
  );
endinterface

// File: rtl/conv_dense_bridge.sv
// Ping-pong buffer that takes the pixel-major convolution stream and replays it
// channel-major (flattened) to the dense stage in OutLanes-wide beats.
module conv_dense_bridge #(
  parameter int BitSize  = 32,
  parameter int NumK     = 4,
  parameter int InLanes  = 2,
  parameter int NumPix   = 4,
  parameter int OutLanes = 2
) (
  input logic                clk,
  input logic                res,
  conv_dense_bridge_if.slave bus
);
  localparam int CPP      = NumK / InLanes;
  localparam int Total    = NumK * NumPix;
  localparam int OutBeats = Total / OutLanes;
  localparam int AW       = (Total > 1)    ? $clog2(Total)    : 1;
  localparam int CW       = (CPP > 1)      ? $clog2(CPP)      : 1;
  localparam int PW       = (NumPix > 1)   ? $clog2(NumPix)   : 1;
  localparam int OW       = (OutBeats > 1) ? $clog2(OutBeats) : 1;

  localparam logic [1:0] S_FREE     = 2'd0;
  localparam logic [1:0] S_FILLING  = 2'd1;
  localparam logic [1:0] S_FULL     = 2'd2;
  localparam logic [1:0] S_DRAINING = 2'd3;

  logic [1:0][1:0]                  bank_state;
  logic                             fill_ptr;
  logic                             drain_ptr;
  logic [CW-1:0]                    sub_cnt;
  logic [PW-1:0]                    pix_cnt;
  logic [OW-1:0]                    beat_cnt;
  logic [BitSize-1:0]               mem [2][Total];

  logic                             accept;
  logic                             fill_busy;
  logic                             fill_last;
  logic                             discard;
  logic                             out_fire;
  logic                             drain_last;
  logic [AW-1:0]                    wr_addr [InLanes];
  logic [OW-1:0]                    rd_beat;
  logic [OutLanes-1:0][BitSize-1:0] rd_data;

  assign bus.in_ready = (bank_state[fill_ptr] == S_FREE) ||
                        (bank_state[fill_ptr] == S_FILLING);
  assign accept     = bus.in_valid && bus.in_ready;
  assign fill_busy  = (sub_cnt != '0) || (pix_cnt != '0);
  assign fill_last  = (sub_cnt == CW'(CPP - 1)) && (pix_cnt == PW'(NumPix - 1));
  // A set_done that coincides with the completing beat is a normal end of set.
  assign discard    = bus.in_set_done && fill_busy && !(accept && fill_last);
  assign out_fire   = bus.out_valid && bus.out_ready;
  assign drain_last = (beat_cnt == OW'(OutBeats - 1));

  // Lane l of sub-cycle c is channel c*InLanes+l; store channel-major.
  always_comb begin
    for (int l = 0; l < InLanes; l++) begin
      wr_addr[l] = AW'((int'(sub_cnt) * InLanes + l) * NumPix + int'(pix_cnt));
    end
  end

  // Beat to present next: 0 when starting a set, otherwise the successor.
  always_comb begin
    rd_beat = bus.out_valid ? beat_cnt + OW'(1) : '0;
    for (int i = 0; i < OutLanes; i++) begin
      rd_data[i] = mem[drain_ptr][AW'(int'(rd_beat) * OutLanes + i)];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int l = 0; l < InLanes; l++) begin
        mem[fill_ptr][wr_addr[l]] <= bus.in_data[l];
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      bank_state    <= {S_FREE, S_FREE};
      fill_ptr      <= 1'b0;
      drain_ptr     <= 1'b0;
      sub_cnt       <= '0;
      pix_cnt       <= '0;
      beat_cnt      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_err   <= 1'b0;
    end else begin
      // fill side
      if ((bus.in_valid && !bus.in_ready) || discard) begin
        bus.out_err <= 1'b1;
      end
      if (discard) begin
        bank_state[fill_ptr] <= S_FREE;
        sub_cnt              <= '0;
        pix_cnt              <= '0;
      end else if (accept) begin
        if (fill_last) begin
          bank_state[fill_ptr] <= S_FULL;
          sub_cnt              <= '0;
          pix_cnt              <= '0;
          fill_ptr             <= ~fill_ptr;
        end else begin
          bank_state[fill_ptr] <= S_FILLING;
          if (sub_cnt == CW'(CPP - 1)) begin
            sub_cnt <= '0;
            pix_cnt <= pix_cnt + PW'(1);
          end else begin
            sub_cnt <= sub_cnt + CW'(1);
          end
        end
      end

      // drain side
      if (out_fire) begin
        if (drain_last) begin
          bus.out_valid         <= 1'b0;
          bus.out_last          <= 1'b0;
          beat_cnt              <= '0;
          bank_state[drain_ptr] <= S_FREE;
          drain_ptr             <= ~drain_ptr;
          // Claim an already-full partner now so the gap between sets is one cycle.
          if (bank_state[~drain_ptr] == S_FULL) begin
            bank_state[~drain_ptr] <= S_DRAINING;
          end
        end else begin
          beat_cnt     <= rd_beat;
          bus.out_data <= rd_data;
          bus.out_last <= (rd_beat == OW'(OutBeats - 1));
        end
      end else if (!bus.out_valid && bank_state[drain_ptr] == S_DRAINING) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= rd_data;
        beat_cnt      <= '0;
        bus.out_last  <= (OutBeats == 1);
      end else if (bank_state[drain_ptr] == S_FULL) begin
        bank_state[drain_ptr] <= S_DRAINING;
      end
    end
  end
endmodule
